// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU writeback sources, the issue stage and
// the register file write port, as seen by the arbiter (slave) and its users (master).
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            a_valid;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_wd;
    logic            a_ready;
    logic            b_valid;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_wd;
    logic            b_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard_rs1;
    logic            hazard_rs2;
    logic            hazard_rd;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;

    modport master (
        output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
        output issue_valid, issue_rd, rs1, rs2,
        input  a_ready, b_ready, hazard_rs1, hazard_rs2, hazard_rd,
        input  rf_we, rf_rd, rf_wd
    );

    modport slave (
        input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
        input  issue_valid, issue_rd, rs1, rs2,
        output a_ready, b_ready, hazard_rs1, hazard_rs2, hazard_rd,
        output rf_we, rf_rd, rf_wd
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and
// LSU (B), plus a pending-write scoreboard that flags RAW/WAW hazards at issue.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_wb_arbiter_if.slave   wb
);
    localparam int NREG = 2 ** AW;

    // last_r = 1 means B owned the previous transfer, so A wins the next tie.
    logic            last_r;
    logic            grant_a_s;
    logic            grant_b_s;
    logic            xfer_s;
    logic [AW-1:0]   sel_rd_s;
    logic [XLEN-1:0] sel_wd_s;
    logic            rf_we_r;
    logic [AW-1:0]   rf_rd_r;
    logic [XLEN-1:0] rf_wd_r;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Grant selection: single requester wins outright, ties go to the port not served last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (wb.a_valid && wb.b_valid) begin
            if (last_r) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (wb.a_valid) begin
            grant_a_s = 1'b1;
        end else if (wb.b_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Mux the granted request onto the write port.
    always_comb begin
        sel_rd_s = wb.a_rd;
        sel_wd_s = wb.a_wd;
        if (grant_b_s) begin
            sel_rd_s = wb.b_rd;
            sel_wd_s = wb.b_wd;
        end else begin
            sel_rd_s = wb.a_rd;
            sel_wd_s = wb.a_wd;
        end
    end

    assign xfer_s     = grant_a_s | grant_b_s;
    assign wb.a_ready = grant_a_s;
    assign wb.b_ready = grant_b_s;

    // Register file write port; an x0 write is accepted but leaves rf_we low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_r <= 1'b0;
            rf_rd_r <= {AW{1'b0}};
            rf_wd_r <= {XLEN{1'b0}};
            last_r  <= 1'b1;
        end else if (xfer_s) begin
            rf_we_r <= (sel_rd_s != {AW{1'b0}});
            rf_rd_r <= sel_rd_s;
            rf_wd_r <= sel_wd_s;
            last_r  <= grant_b_s;
        end else begin
            rf_we_r <= 1'b0;
        end
    end

    assign wb.rf_we = rf_we_r;
    assign wb.rf_rd = rf_rd_r;
    assign wb.rf_wd = rf_wd_r;

    // Set is applied after clear so a newly issued owner keeps the register busy.
    assign clr_mask_s = rf_we_r ? onehot(rf_rd_r) : {NREG{1'b0}};
    assign set_mask_s = (wb.issue_valid && (wb.issue_rd != {AW{1'b0}})) ?
                        onehot(wb.issue_rd) : {NREG{1'b0}};
    assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~onehot({AW{1'b0}});

    // Pending-write scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign wb.hazard_rs1 = busy_r[wb.rs1];
    assign wb.hazard_rs2 = busy_r[wb.rs2];
    assign wb.hazard_rd  = busy_r[wb.issue_rd];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter: combinational grants/hazards are checked
// per vector, registered write-port outputs through an expectation queue.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) wb ();

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] awd;
        logic        bv;  logic [4:0] brd; logic [31:0] bwd;
        logic        iv;  logic [4:0] ird; logic [4:0]  rs1; logic [4:0] rs2;
        logic        ea;  logic       eb;
        logic        eh1; logic       eh2; logic        ehd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } rf_exp_t;

    rf_exp_t     sbq[$];
    vec_t        tbl[15];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [4:0]  m_rd   = 5'd0;
    logic [31:0] m_wd   = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        wb.a_valid     = v.av;  wb.a_rd = v.ard; wb.a_wd = v.awd;
        wb.b_valid     = v.bv;  wb.b_rd = v.brd; wb.b_wd = v.bwd;
        wb.issue_valid = v.iv;  wb.issue_rd = v.ird;
        wb.rs1         = v.rs1; wb.rs2 = v.rs2;
    endtask

    task automatic pop_check();
        rf_exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rf_we", {31'd0, wb.rf_we}, {31'd0, e.we});
            check("rf_rd", {27'd0, wb.rf_rd}, {27'd0, e.rd});
            check("rf_wd", wb.rf_wd, e.wd);
        end
    endtask

    // One cycle: check last cycle's write, drive, check grants/hazards, queue the expected write.
    task automatic apply(input vec_t v, input int idx);
        rf_exp_t e;
        @(posedge clk); #1;
        pop_check();
        drive(v);
        #3;
        check($sformatf("a_ready[%0d]", idx), {31'd0, wb.a_ready}, {31'd0, v.ea});
        check($sformatf("b_ready[%0d]", idx), {31'd0, wb.b_ready}, {31'd0, v.eb});
        check($sformatf("hz_rs1[%0d]", idx), {31'd0, wb.hazard_rs1}, {31'd0, v.eh1});
        check($sformatf("hz_rs2[%0d]", idx), {31'd0, wb.hazard_rs2}, {31'd0, v.eh2});
        check($sformatf("hz_rd[%0d]", idx), {31'd0, wb.hazard_rd}, {31'd0, v.ehd});
        if (v.ea) begin
            m_rd = v.ard; m_wd = v.awd; e.we = (v.ard != 5'd0);
        end else if (v.eb) begin
            m_rd = v.brd; m_wd = v.bwd; e.we = (v.brd != 5'd0);
        end else begin
            e.we = 1'b0;
        end
        e.rd = m_rd;
        e.wd = m_wd;
        sbq.push_back(e);
    endtask

    task automatic flush();
        vec_t idle;
        idle = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        @(posedge clk); #1;
        pop_check();
        drive(idle);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wb.a_valid = 1'b1; wb.b_valid = 1'b1;
        wb.a_rd = 5'd3; wb.b_rd = 5'd4; wb.a_wd = 32'd1; wb.b_wd = 32'd2;
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd5; wb.rs1 = 5'd5; wb.rs2 = 5'd6;
        #12;
        check("rst_rf_we", {31'd0, wb.rf_we}, 32'd0);
        check("rst_rf_rd", {27'd0, wb.rf_rd}, 32'd0);
        check("rst_rf_wd", wb.rf_wd, 32'd0);
        check("rst_a_ready", {31'd0, wb.a_ready}, 32'd1);
        check("rst_b_ready", {31'd0, wb.b_ready}, 32'd0);
        check("rst_hz_rs1", {31'd0, wb.hazard_rs1}, 32'd0);
        check("rst_hz_rd", {31'd0, wb.hazard_rd}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wb.a_valid = 1'b0; wb.b_valid = 1'b0; wb.issue_valid = 1'b0;
        wb.issue_rd = 5'd0; wb.rs1 = 5'd0; wb.rs2 = 5'd0;
        sbq.delete();
        m_rd = 5'd0;
        m_wd = 32'd0;
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        //        av    ard    awd        bv    brd    bwd       iv    ird    rs1    rs2    ea    eb    eh1   eh2   ehd
        tbl[0]  = '{1'b1, 5'd5, 32'h55,    1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd5, 32'h55,    1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd5, 32'h55,    1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd5, 32'h55,    1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = idle;
        tbl[5]  = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 5'd9, 32'h99,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 5'd0, 32'hFFFF,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Lone ALU write straight out of reset: granted, written next cycle, then idle.
        do_reset();
        v = '{1'b1, 5'd3, 32'h12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        apply(v, 100);
        apply(idle, 101);
        apply(idle, 102);
        flush();

        // Contention, scoreboard set/clear, same-cycle set-wins and x0 writes.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], i);
        end
        flush();

        // Mark x4/x8 pending, commit a write, then assert reset while rf_we is high.
        v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply(v, 200);
        v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd4, 5'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply(v, 201);
        v = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd8,
              1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply(v, 202);
        flush();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rf_we", {31'd0, wb.rf_we}, 32'd0);
        check("midrst_rf_wd", wb.rf_wd, 32'd0);
        #2;
        reset_n = 1'b1;
        wb.rs1 = 5'd4; wb.rs2 = 5'd8; wb.issue_rd = 5'd4;
        #1;
        check("post_rst_hz_rs1", {31'd0, wb.hazard_rs1}, 32'd0);
        check("post_rst_hz_rs2", {31'd0, wb.hazard_rs2}, 32'd0);
        check("post_rst_hz_rd", {31'd0, wb.hazard_rd}, 32'd0);
        sbq.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and pending-write scoreboard for the 32x32 integer register file. It shares the register file's single write port between two writeback sources, the ALU (port A) and the load/store unit (port B), using round-robin arbitration. It also tracks which destination registers have writes in flight, so the issue stage can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file's we/rd/wd inputs.

## Interface
- XLEN, 32, data width of the write port
- AW, 5, register address width (2**AW registers, x0 hardwired zero)
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  ALU writeback request
- a_rd  in  AW  ALU destination register
- a_wd  in  XLEN  ALU result
- a_ready  out  1  ALU request granted this cycle
- b_valid  in  1  LSU writeback request
- b_rd  in  AW  LSU destination register
- b_wd  in  XLEN  LSU load data
- b_ready  out  1  LSU request granted this cycle
- issue_valid  in  1  instruction issued this cycle, marks issue_rd pending
- issue_rd  in  AW  destination of issued instruction
- rs1, rs2  in  AW each  source registers of the instruction in decode
- hazard_rs1, hazard_rs2, hazard_rd  out  1 each  pending write exists for rs1 / rs2 / issue_rd
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  AW  register file write address (registered)
- rf_wd  out  XLEN  register file write data (registered)

## Operation
- Handshake: a transfer occurs on port X when X_valid && X_ready at the rising edge. Requesters hold rd/wd stable while valid && !ready. Once valid is asserted, it is not dropped before ready.
- Grant (combinational): at most one of a_ready/b_ready per cycle.
  - Only one valid: that port is granted.
  - Both valid: the port not granted last time is granted.
  - Round-robin pointer `last` updates only on an actual transfer. It resets to B, so A wins the first tie.
- Accepted transfer: rf_we <= (rd != 0), rf_rd <= rd, rf_wd <= wd.
- No transfer: rf_we <= 0, and rf_rd/rf_wd hold their previous values.
- A write to x0 is consumed (ready asserted) but never reaches the register file and never touches the scoreboard.
- Scoreboard: a busy[2**AW] vector; busy[0] is constant 0.
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the edge.
  - Clear: rf_we clears busy[rf_rd] at the edge, i.e. the edge where the register file commits the write.
  - Same index set and cleared in the same cycle: set wins, because the newer instruction owns the register.
- Hazards (combinational): hazard_rs1 = busy[rs1], hazard_rs2 = busy[rs2], hazard_rd = busy[issue_rd]. Any of them is 0 when its index is 0.
- The issue stage must not assert issue_valid while hazard_rd is 1 (single outstanding write per register). The block does not detect violations.

## Timing
- Reset (reset_n low, asynchronous):
  - rf_we=0, rf_rd=0, rf_wd=0.
  - busy all 0, `last`=B.
  - a_ready/b_ready follow the valid inputs combinationally (A granted on a tie).
  - hazard outputs 0.
- Reset mid-operation drops any in-flight rf_we immediately and clears all pending marks. No write completes.
- Latency:
  - Transfer edge to rf_we high: 1 cycle.
  - rf_we high to busy cleared: same edge as the register file write. A reader in the following cycle sees the new value with its hazard flag low.
  - The source register still reads busy during the cycle rf_we is high; no bypass is provided.
- Throughput: one write per cycle. Under continuous contention each port gets every other cycle, so there is no starvation.
- issue_valid and a transfer in the same cycle are independent, and both take effect at that edge.

## Test plan
- Reset, then a_valid=1, a_rd=3, a_wd=0x12 alone -> a_ready=1 same cycle; next cycle rf_we=1, rf_rd=3, rf_wd=0x12; the cycle after, rf_we=0.
- a_valid and b_valid held high for 4 cycles (rd 5 and 6) -> grants A,B,A,B; rf_rd sequence 5,6,5,6; never both ready in one cycle.
- issue_valid with issue_rd=7 -> hazard_rs1=1 when rs1=7; b writes rd=7 -> hazard stays 1 during the rf_we cycle, then 0 the next cycle.
- Same cycle: issue_rd=9 and rf_we=1 with rf_rd=9 -> busy[9] remains 1 and hazard_rd=1 afterwards.
- a_valid with a_rd=0, a_wd=0xFFFF -> a_ready=1, rf_we stays 0, busy[0] and hazard outputs stay 0.
- Mark x4 and x8 pending, accept a write, assert reset_n=0 mid-cycle -> rf_we drops to 0 immediately; all hazards 0 after release.
